// File: rtl/trace_capture_pkg.sv
// Shared grid geometry, FSM state encoding and cell-index helper for the
// spell trace capture path and the trace renderer.
package trace_capture_pkg;

  localparam int GRID_ROW0 = 40;
  localparam int GRID_COL0 = 120;
  localparam int CELL_PX   = 100;
  localparam int GRID_N    = 4;
  localparam int N_CELLS   = GRID_N * GRID_N;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_TRACE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Cell 0 is top-left, cell 15 bottom-right; same order the renderer uses.
  function automatic logic [3:0] cell_index(input logic [1:0] grid_row,
                                            input logic [1:0] grid_col);
    return {grid_row, grid_col};
  endfunction

endpackage

// File: rtl/trace_capture_grid_cell_map.sv
// Combinational screen position -> 4x4 grid cell lookup built from compare
// chains. A boundary pixel belongs to the lower/right cell.
module grid_cell_map
  import trace_capture_pkg::*;
(
  input  logic [8:0] i_row,
  input  logic [9:0] i_col,
  output logic       o_in_grid,
  output logic [3:0] o_cell
);

  localparam logic [8:0] ROW_LO = 9'(GRID_ROW0);
  localparam logic [8:0] ROW_B1 = 9'(GRID_ROW0 + CELL_PX);
  localparam logic [8:0] ROW_B2 = 9'(GRID_ROW0 + 2 * CELL_PX);
  localparam logic [8:0] ROW_B3 = 9'(GRID_ROW0 + 3 * CELL_PX);
  localparam logic [8:0] ROW_HI = 9'(GRID_ROW0 + GRID_N * CELL_PX - 1);

  localparam logic [9:0] COL_LO = 10'(GRID_COL0);
  localparam logic [9:0] COL_B1 = 10'(GRID_COL0 + CELL_PX);
  localparam logic [9:0] COL_B2 = 10'(GRID_COL0 + 2 * CELL_PX);
  localparam logic [9:0] COL_B3 = 10'(GRID_COL0 + 3 * CELL_PX);
  localparam logic [9:0] COL_HI = 10'(GRID_COL0 + GRID_N * CELL_PX - 1);

  logic [1:0] w_grid_row;
  logic [1:0] w_grid_col;

  always_comb begin
    w_grid_row = 2'd0;
    if (i_row >= ROW_B3) begin
      w_grid_row = 2'd3;
    end else if (i_row >= ROW_B2) begin
      w_grid_row = 2'd2;
    end else if (i_row >= ROW_B1) begin
      w_grid_row = 2'd1;
    end else begin
      w_grid_row = 2'd0;
    end
  end

  always_comb begin
    w_grid_col = 2'd0;
    if (i_col >= COL_B3) begin
      w_grid_col = 2'd3;
    end else if (i_col >= COL_B2) begin
      w_grid_col = 2'd2;
    end else if (i_col >= COL_B1) begin
      w_grid_col = 2'd1;
    end else begin
      w_grid_col = 2'd0;
    end
  end

  assign o_in_grid = (i_row >= ROW_LO) && (i_row <= ROW_HI) &&
                     (i_col >= COL_LO) && (i_col <= COL_HI);
  assign o_cell    = cell_index(w_grid_row, w_grid_col);

endmodule

// File: rtl/trace_capture.sv
// Spell trace capture: marks each 4x4 grid cell the wand cursor dwells in and
// reports the final 16-bit bitmap when capture stops or times out.
module trace_capture
  import trace_capture_pkg::*;
#(
  parameter int DWELL_CYC   = 2_500_000,
  parameter int TIMEOUT_CYC = 150_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 pos_valid,
  input  logic [8:0]           pos_row,
  input  logic [9:0]           pos_col,
  output logic [N_CELLS-1:0]   trace,
  output logic                 trace_valid,
  output logic                 busy,
  output logic [4:0]           cell_count
);

  localparam int DW = $clog2(DWELL_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_CYC);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_inq;
  logic [3:0]          r_cell_q;
  logic [3:0]          r_cell_prev;
  logic [DW-1:0]       r_dwell;
  logic [DW-1:0]       w_dwell_nxt;
  logic [TW-1:0]       r_timeout;
  logic [N_CELLS-1:0]  r_trace;
  logic [4:0]          r_cell_count;
  logic                r_trace_valid;
  logic                r_busy;
  logic                w_in_grid;
  logic [3:0]          w_cell;
  logic                w_mark;

  grid_cell_map u_grid_cell_map (
    .i_row     (pos_row),
    .i_col     (pos_col),
    .o_in_grid (w_in_grid),
    .o_cell    (w_cell)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_ARM;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ARM: w_state_nxt = ST_TRACE;
      ST_TRACE: begin
        if (stop || (r_timeout == TO_LAST)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_TRACE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Run length of consecutive in-grid samples in the same cell, saturating.
  always_comb begin
    w_dwell_nxt = r_dwell;
    if (!r_inq) begin
      w_dwell_nxt = '0;
    end else if (r_cell_q != r_cell_prev) begin
      w_dwell_nxt = DW'(1);
    end else if (r_dwell == DWELL_MAX) begin
      w_dwell_nxt = r_dwell;
    end else begin
      w_dwell_nxt = r_dwell + DW'(1);
    end
  end

  assign w_mark = (r_state == ST_TRACE) && r_inq &&
                  (w_dwell_nxt == DWELL_MAX) && !r_trace[r_cell_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_inq         <= 1'b0;
      r_cell_q      <= 4'd0;
      r_cell_prev   <= 4'd0;
      r_dwell       <= '0;
      r_timeout     <= '0;
      r_trace       <= '0;
      r_cell_count  <= 5'd0;
      r_trace_valid <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_inq         <= pos_valid & w_in_grid;
      r_cell_q      <= w_cell;
      r_cell_prev   <= r_cell_q;
      r_trace_valid <= (w_state_nxt == ST_DONE);
      r_busy        <= (w_state_nxt == ST_ARM) || (w_state_nxt == ST_TRACE);
      case (r_state)
        ST_ARM: begin
          r_dwell      <= '0;
          r_timeout    <= '0;
          r_trace      <= '0;
          r_cell_count <= 5'd0;
        end
        ST_TRACE: begin
          r_dwell <= w_dwell_nxt;
          // A new mark restarts the inactivity timeout.
          if (w_mark) begin
            r_trace[r_cell_q] <= 1'b1;
            r_cell_count      <= r_cell_count + 5'd1;
            r_timeout         <= '0;
          end else if (r_timeout != TO_LAST) begin
            r_timeout <= r_timeout + TW'(1);
          end else begin
            r_timeout <= r_timeout;
          end
        end
        default: begin
          r_dwell <= r_dwell;
        end
      endcase
    end
  end

  assign trace       = r_trace;
  assign trace_valid = r_trace_valid;
  assign busy        = r_busy;
  assign cell_count  = r_cell_count;

endmodule
